// File: rtl/pmos_pwr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pmos_pwr_pkg
// Brief   : State encoding and sizing helper for the PMOS header sequencer.
// Revision: 1.0  initial release
// ============================================================================
package pmos_pwr_pkg;

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_RAMP_UP   = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_ON        = 3'd3;
    localparam logic [2:0] ST_ISO       = 3'd4;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd5;

    // Bits needed to hold values 0..n inclusive, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmos_stage_timer.sv
`default_nettype none
// ============================================================================
// Module  : pmos_stage_timer
// Brief   : Cycle timer shared by the ramp, settle and isolation phases.
// Revision: 1.0  initial release
// ============================================================================
module pmos_stage_timer
    import pmos_pwr_pkg::*;
#(
    parameter int MAX = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic [cnt_width(MAX)-1:0] len,
    output logic                      done
);

    localparam int c_W = cnt_width(MAX);

    logic [c_W-1:0] r_cnt;

    // done marks the len-th enabled cycle; the counter wraps on that same edge.
    assign done = (r_cnt == len - c_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pmos_header_switch_seq.sv
`default_nettype none
// ============================================================================
// Module  : pmos_header_switch_seq
// Brief   : Staggered on/off sequencer for a bank of PMOS header switches.
// Revision: 1.0  initial release
// ============================================================================
module pmos_header_switch_seq
    import pmos_pwr_pkg::*;
#(
    parameter int NUM_SW     = 4,
    parameter int STAGE_DLY  = 2,
    parameter int SETTLE_CYC = 3,
    parameter int ISO_SETUP  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pwr_req,
    output logic                          pwr_ack,
    output logic                          iso_en,
    output logic                          busy,
    output logic [NUM_SW-1:0]             sw_gate_n,
    output logic [$clog2(NUM_SW+1)-1:0]   sw_on_cnt
);

    localparam int c_CW   = cnt_width(NUM_SW);
    localparam int c_TMAX = (STAGE_DLY > SETTLE_CYC)
                          ? ((STAGE_DLY  > ISO_SETUP) ? STAGE_DLY  : ISO_SETUP)
                          : ((SETTLE_CYC > ISO_SETUP) ? SETTLE_CYC : ISO_SETUP);
    localparam int c_TW   = cnt_width(c_TMAX);

    localparam logic [c_TW-1:0] c_LEN_STAGE  = c_TW'(STAGE_DLY);
    localparam logic [c_TW-1:0] c_LEN_SETTLE = c_TW'(SETTLE_CYC);
    localparam logic [c_TW-1:0] c_LEN_ISO    = c_TW'(ISO_SETUP);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [c_CW-1:0]  w_cnt_nxt;
    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic             w_tmr_done;
    logic [c_TW-1:0]  w_tmr_len;

    // Thermometer gate pattern: switch i conducts (gate low) when i < n.
    function automatic logic [NUM_SW-1:0] therm_gate_n(input logic [c_CW-1:0] n);
        logic [NUM_SW-1:0] g;
        for (int i = 0; i < NUM_SW; i++) begin
            g[i] = !(i < int'(n));
        end
        return g;
    endfunction

    assign w_tmr_len = (r_state == ST_SETTLE) ? c_LEN_SETTLE :
                       (r_state == ST_ISO)    ? c_LEN_ISO    : c_LEN_STAGE;

    pmos_stage_timer #(
        .MAX (c_TMAX)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tmr_clr),
        .en   (w_tmr_en),
        .len  (w_tmr_len),
        .done (w_tmr_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = sw_on_cnt;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        case (r_state)
            ST_OFF: begin
                w_tmr_clr = 1'b1;
                if (pwr_req) begin
                    w_state_nxt = ST_RAMP_UP;
                    w_cnt_nxt   = c_CW'(1);
                end
            end
            ST_RAMP_UP: begin
                if (!pwr_req) begin
                    w_state_nxt = ST_RAMP_DOWN;
                    w_tmr_clr   = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_done) begin
                        if (sw_on_cnt == c_CW'(NUM_SW)) begin
                            w_state_nxt = ST_SETTLE;
                        end else begin
                            w_cnt_nxt = sw_on_cnt + c_CW'(1);
                        end
                    end
                end
            end
            ST_SETTLE: begin
                if (!pwr_req) begin
                    w_state_nxt = ST_RAMP_DOWN;
                    w_tmr_clr   = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_done) begin
                        w_state_nxt = ST_ON;
                    end
                end
            end
            ST_ON: begin
                w_tmr_clr = 1'b1;
                if (!pwr_req) begin
                    w_state_nxt = ST_ISO;
                end
            end
            ST_ISO: begin
                // Isolation setup always runs to completion.
                w_tmr_en = 1'b1;
                if (w_tmr_done) begin
                    w_state_nxt = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (pwr_req) begin
                    w_state_nxt = ST_RAMP_UP;
                    w_tmr_clr   = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_done) begin
                        w_cnt_nxt = sw_on_cnt - c_CW'(1);
                        if (sw_on_cnt == c_CW'(1)) begin
                            w_state_nxt = ST_OFF;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_cnt_nxt   = '0;
                w_tmr_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_OFF;
            sw_on_cnt <= '0;
            sw_gate_n <= '1;
            iso_en    <= 1'b1;
            pwr_ack   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            sw_on_cnt <= w_cnt_nxt;
            sw_gate_n <= therm_gate_n(w_cnt_nxt);
            pwr_ack   <= (w_state_nxt == ST_ON);
            iso_en    <= (w_state_nxt != ST_ON);
            busy      <= (w_state_nxt != ST_ON) && (w_state_nxt != ST_OFF);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmos_header_switch_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_pmos_header_switch_seq
// Brief   : Directed and randomized bench with a phase-level reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_pmos_header_switch_seq;

    localparam int NSW = 4;
    localparam int SD  = 2;
    localparam int SC  = 3;
    localparam int IS  = 1;

    localparam int P_OFF = 0, P_UP = 1, P_SETTLE = 2, P_ON = 3, P_ISO = 4, P_DOWN = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           pwr_req = 1'b0;
    logic           pwr_ack;
    logic           iso_en;
    logic           busy;
    logic [NSW-1:0] sw_gate_n;
    logic [2:0]     sw_on_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int m_phase = P_OFF;
    int m_cnt   = 0;
    int m_el    = 0;

    pmos_header_switch_seq #(
        .NUM_SW     (NSW),
        .STAGE_DLY  (SD),
        .SETTLE_CYC (SC),
        .ISO_SETUP  (IS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwr_req   (pwr_req),
        .pwr_ack   (pwr_ack),
        .iso_en    (iso_en),
        .busy      (busy),
        .sw_gate_n (sw_gate_n),
        .sw_on_cnt (sw_on_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Phase-level model: elapsed cycles in the current phase drive each step.
    task automatic model_edge(input logic r, input logic q);
        if (r) begin
            m_phase = P_OFF; m_cnt = 0; m_el = 0;
        end else begin
            case (m_phase)
                P_OFF: if (q) begin m_phase = P_UP; m_cnt = 1; m_el = 0; end
                P_UP: begin
                    if (!q) begin m_phase = P_DOWN; m_el = 0; end
                    else begin
                        m_el++;
                        if (m_el == SD) begin
                            m_el = 0;
                            if (m_cnt == NSW) m_phase = P_SETTLE;
                            else m_cnt++;
                        end
                    end
                end
                P_SETTLE: begin
                    if (!q) begin m_phase = P_DOWN; m_el = 0; end
                    else begin
                        m_el++;
                        if (m_el == SC) begin m_phase = P_ON; m_el = 0; end
                    end
                end
                P_ON: if (!q) begin m_phase = P_ISO; m_el = 0; end
                P_ISO: begin
                    m_el++;
                    if (m_el == IS) begin m_phase = P_DOWN; m_el = 0; end
                end
                default: begin
                    if (q) begin m_phase = P_UP; m_el = 0; end
                    else begin
                        m_el++;
                        if (m_el == SD) begin
                            m_el = 0;
                            m_cnt--;
                            if (m_cnt == 0) m_phase = P_OFF;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        int g;
        g = ((1 << NSW) - 1) & ~((1 << m_cnt) - 1);
        check_eq("gate", 32'(sw_gate_n), 32'(g));
        check_eq("cnt", 32'(sw_on_cnt), 32'(m_cnt));
        check_eq("ack", 32'(pwr_ack), 32'(m_phase == P_ON));
        check_eq("iso", 32'(iso_en), 32'(m_phase != P_ON));
        check_eq("busy", 32'(busy), 32'(m_phase != P_ON && m_phase != P_OFF));
        check_eq("iso_low_needs_all_on", 32'(!iso_en && (sw_gate_n != '0)), 32'(0));
    endtask

    task automatic step(input logic r, input logic q);
        rst = r;
        pwr_req = q;
        @(posedge clk);
        model_edge(r, q);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic q;
        int   len;

        // Reset with request high
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_eq("rst_gate", 32'(sw_gate_n), 32'h0000_000F);
        check_eq("rst_cnt", 32'(sw_on_cnt), 32'(0));
        check_eq("rst_iso", 32'(iso_en), 32'(1));

        // Full power-up
        for (int k = 0; k <= 11; k++) begin
            step(1'b0, 1'b1);
            if (k == 0) check_eq("up_gate_e0", 32'(sw_gate_n), 32'h0000_000E);
            if (k == 2) check_eq("up_gate_e2", 32'(sw_gate_n), 32'h0000_000C);
            if (k == 4) check_eq("up_gate_e4", 32'(sw_gate_n), 32'h0000_0008);
            if (k == 6) check_eq("up_gate_e6", 32'(sw_gate_n), 32'h0000_0000);
            if (k == 10) check_eq("up_ack_e10", 32'(pwr_ack), 32'(0));
            if (k == 11) begin
                check_eq("up_ack_e11", 32'(pwr_ack), 32'(1));
                check_eq("up_iso_e11", 32'(iso_en), 32'(0));
            end
        end

        // Full power-down from ON
        for (int k = 0; k <= 9; k++) begin
            step(1'b0, 1'b0);
            if (k == 0) check_eq("dn_iso_e0", 32'(iso_en), 32'(1));
            if (k == 2) check_eq("dn_cnt_e2", 32'(sw_on_cnt), 32'(4));
            if (k == 3) check_eq("dn_cnt_e3", 32'(sw_on_cnt), 32'(3));
            if (k == 9) begin
                check_eq("dn_cnt_e9", 32'(sw_on_cnt), 32'(0));
                check_eq("dn_busy_e9", 32'(busy), 32'(0));
            end
        end

        // Abort of a ramp-up at two switches
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        for (int j = 0; j <= 4; j++) begin
            step(1'b0, 1'b0);
            check_eq("abup_ack", 32'(pwr_ack), 32'(0));
            if (j == 2) check_eq("abup_cnt_j2", 32'(sw_on_cnt), 32'(1));
            if (j == 4) check_eq("abup_cnt_j4", 32'(sw_on_cnt), 32'(0));
        end

        // Abort of a ramp-down at three switches
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0);
        check_eq("abdn_start_cnt", 32'(sw_on_cnt), 32'(3));
        for (int j = 0; j <= 7; j++) begin
            step(1'b0, 1'b1);
            if (j == 2) check_eq("abdn_cnt_j2", 32'(sw_on_cnt), 32'(4));
            if (j == 6) check_eq("abdn_ack_j6", 32'(pwr_ack), 32'(0));
            if (j == 7) check_eq("abdn_ack_j7", 32'(pwr_ack), 32'(1));
        end

        // Reset in the middle of a ramp-up
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        check_eq("mid_cnt_pre", 32'(sw_on_cnt), 32'(2));
        step(1'b1, 1'b1);
        check_eq("mid_gate", 32'(sw_gate_n), 32'h0000_000F);
        check_eq("mid_busy", 32'(busy), 32'(0));

        // Randomized request levels with occasional reset
        for (int n = 0; n < 60; n++) begin
            q   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            for (int j = 0; j < len; j++) begin
                step(($urandom_range(0, 79) == 0), q);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
